// File: rtl/icache_pkg.sv
// Shared definitions for the n-way instruction cache: controller states and address split.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package icache_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LOOKUP   = 3'd1,
      MISS_REQ = 3'd2,
      FILL     = 3'd3,
      FLUSH    = 3'd4
   } state_t;

   // Byte-offset field: word select plus the two ignored byte bits.
   function automatic int offset_w(input int line_words);
      return $clog2(line_words) + 2;
   endfunction

   function automatic int index_w(input int num_sets);
      return $clog2(num_sets);
   endfunction

   function automatic int tag_w(input int num_sets, input int line_words);
      return 32 - offset_w(line_words) - index_w(num_sets);
   endfunction

endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU for one set: victim choice (first invalid way, else tree walk) and access update.
// Latency: purely combinational.
// Backpressure: none; caller decides when to commit tree_o.
module plru_tree #(
   parameter int NUM_WAYS = 4
) (
   input  logic [NUM_WAYS-2:0]         tree_i,
   input  logic [NUM_WAYS-1:0]         valid_i,
   input  logic [$clog2(NUM_WAYS)-1:0] access_way_i,
   output logic [$clog2(NUM_WAYS)-1:0] victim_o,
   output logic [NUM_WAYS-2:0]         tree_o
);
   localparam int WAY_W = $clog2(NUM_WAYS);

   // Node n has children 2n+1 (left) and 2n+2 (right); a node bit of 1 points the victim right.
   int   vnode;
   int   unode;
   logic vfound;

   // Victim: lowest-index invalid way, otherwise follow the node bits from the root.
   always_comb begin
      victim_o = '0;
      vfound   = 1'b0;
      vnode    = 0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (!vfound && !valid_i[w]) begin
            victim_o = w[WAY_W-1:0];
            vfound   = 1'b1;
         end
      end
      if (!vfound) begin
         for (int l = 0; l < WAY_W; l++) begin
            victim_o[WAY_W-1-l] = tree_i[vnode];
            vnode = 2 * vnode + 1 + int'(tree_i[vnode]);
         end
      end
   end

   // Update: every node on the accessed way's path is turned to point at the other subtree.
   always_comb begin
      tree_o = tree_i;
      unode  = 0;
      for (int l = 0; l < WAY_W; l++) begin
         tree_o[unode] = ~access_way_i[WAY_W-1-l];
         unode = 2 * unode + 1 + int'(access_way_i[WAY_W-1-l]);
      end
   end

endmodule

// File: rtl/icache_nway.sv
// N-way set-associative instruction cache with critical-word-first wrapped line fill and fence.i flush.
// Latency: hit responds 1 cycle after acceptance; miss responds with the first fill beat.
// Backpressure: req_ready only in IDLE with no flush pending; mem request held until mem_req_ready; fill stalls on beat gaps.
module icache_nway import icache_pkg::*; #(
   parameter int NUM_WAYS   = 4,
   parameter int NUM_SETS   = 64,
   parameter int LINE_WORDS = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic [31:0] req_addr,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   output logic        hit,
   input  logic        flush,
   output logic        flush_busy,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_resp_data
);
   localparam int OFF_W  = offset_w(LINE_WORDS);
   localparam int IDX_W  = index_w(NUM_SETS);
   localparam int TAG_W  = tag_w(NUM_SETS, LINE_WORDS);
   localparam int WORD_W = $clog2(LINE_WORDS);
   localparam int WAY_W  = $clog2(NUM_WAYS);
   localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(LINE_WORDS - 1);
   localparam logic [IDX_W-1:0]  LAST_SET  = IDX_W'(NUM_SETS - 1);

   state_t              state_q, state_d;
   logic [31:0]         addr_q;
   logic [WAY_W-1:0]    victim_q;
   logic [WORD_W-1:0]   beat_q, beat_d;
   logic [IDX_W-1:0]    fset_q, fset_d;
   logic                flush_pend_q, flush_pend_d;

   logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
   logic [NUM_WAYS-2:0] plru_q  [NUM_SETS];
   logic [TAG_W-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
   logic [31:0]         data_q  [NUM_SETS][NUM_WAYS][LINE_WORDS];

   logic [IDX_W-1:0]    set_idx;
   logic [TAG_W-1:0]    tag_in;
   logic [WORD_W-1:0]   crit_word, wr_word;
   logic                hit_any;
   logic [WAY_W-1:0]    hit_way, victim_sel, touch_way;
   logic [NUM_WAYS-2:0] plru_upd;
   logic                miss_inval, fill_beat, fill_last, plru_we;

   assign set_idx   = addr_q[OFF_W +: IDX_W];
   assign tag_in    = addr_q[31 -: TAG_W];
   assign crit_word = addr_q[2 +: WORD_W];
   assign wr_word   = crit_word + beat_q;   // wraps modulo LINE_WORDS
   assign flush_busy = flush_pend_q || (state_q == FLUSH);
   assign touch_way = (state_q == LOOKUP) ? hit_way : victim_q;

   // Tag compare across all ways of the latched set.
   always_comb begin
      hit_any = 1'b0;
      hit_way = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (!hit_any && valid_q[set_idx][w] && (tag_q[set_idx][w] == tag_in)) begin
            hit_any = 1'b1;
            hit_way = w[WAY_W-1:0];
         end
      end
   end

   plru_tree #(.NUM_WAYS(NUM_WAYS)) u_plru (
      .tree_i       (plru_q[set_idx]),
      .valid_i      (valid_q[set_idx]),
      .access_way_i (touch_way),
      .victim_o     (victim_sel),
      .tree_o       (plru_upd)
   );

   // Controller next state, outputs and array strobes.
   always_comb begin
      state_d       = state_q;
      beat_d        = beat_q;
      fset_d        = '0;
      flush_pend_d  = flush_pend_q;
      req_ready     = 1'b0;
      resp_valid    = 1'b0;
      resp_data     = '0;
      hit           = 1'b0;
      mem_req_valid = 1'b0;
      mem_req_addr  = '0;
      miss_inval    = 1'b0;
      fill_beat     = 1'b0;
      fill_last     = 1'b0;
      plru_we       = 1'b0;
      if (flush && (state_q != IDLE)) flush_pend_d = 1'b1;
      case (state_q)
         IDLE: begin
            // A pending or fresh flush wins over any new request.
            if (flush || flush_pend_q) begin
               state_d      = FLUSH;
               flush_pend_d = 1'b0;
            end else begin
               req_ready = 1'b1;
               if (req_valid) state_d = LOOKUP;
            end
         end
         LOOKUP: begin
            if (hit_any) begin
               resp_valid = 1'b1;
               hit        = 1'b1;
               resp_data  = data_q[set_idx][hit_way][crit_word];
               plru_we    = 1'b1;
               state_d    = IDLE;
            end else begin
               miss_inval = 1'b1;
               state_d    = MISS_REQ;
            end
         end
         MISS_REQ: begin
            mem_req_valid = 1'b1;
            mem_req_addr  = addr_q & 32'hFFFF_FFFC;
            beat_d        = '0;
            if (mem_req_ready) state_d = FILL;
         end
         FILL: begin
            if (mem_resp_valid) begin
               fill_beat = 1'b1;
               beat_d    = beat_q + WORD_W'(1);
               // Critical word is forwarded straight from memory.
               if (beat_q == '0) begin
                  resp_valid = 1'b1;
                  resp_data  = mem_resp_data;
               end
               if (beat_q == LAST_BEAT) begin
                  fill_last = 1'b1;
                  plru_we   = 1'b1;
                  state_d   = IDLE;
               end
            end
         end
         FLUSH: begin
            fset_d = fset_q + IDX_W'(1);
            if (fset_q == LAST_SET) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Controller registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         victim_q     <= '0;
         beat_q       <= '0;
         fset_q       <= '0;
         flush_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         beat_q       <= beat_d;
         fset_q       <= fset_d;
         flush_pend_q <= flush_pend_d;
         if (req_valid && req_ready) addr_q <= req_addr;
         if (miss_inval) victim_q <= victim_sel;
      end
   end

   // Valid bits and PLRU trees: the victim is invalid for the whole fill so an abandoned fill leaves no stale line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            valid_q[s] <= '0;
            plru_q[s]  <= '0;
         end
      end else begin
         if (state_q == FLUSH) begin
            valid_q[fset_q] <= '0;
            plru_q[fset_q]  <= '0;
         end
         if (miss_inval) valid_q[set_idx][victim_sel] <= 1'b0;
         if (fill_last)  valid_q[set_idx][victim_q]   <= 1'b1;
         if (plru_we)    plru_q[set_idx]              <= plru_upd;
      end
   end

   // Tag and data storage; contents survive reset and flush, only the valid bits gate them.
   always_ff @(posedge clk) begin
      if (fill_beat) data_q[set_idx][victim_q][wr_word] <= mem_resp_data;
      if (fill_last) tag_q[set_idx][victim_q]           <= tag_in;
   end

endmodule

// File: tb/tb_icache_nway.sv
// Randomized scoreboard bench for icache_nway against a behavioural cache model.
// Latency: checks hit responses one cycle after acceptance.
// Backpressure: memory model stalls the request and inserts beat gaps.
module tb_icache_nway;
   localparam int NUM_WAYS   = 4;
   localparam int NUM_SETS   = 64;
   localparam int LINE_WORDS = 16;
   localparam int OFF_W      = $clog2(LINE_WORDS) + 2;
   localparam int IDX_W      = $clog2(NUM_SETS);

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic [31:0] req_addr = '0;
   logic        req_ready, resp_valid, hit, flush_busy, mem_req_valid;
   logic [31:0] resp_data, mem_req_addr;
   logic        flush = 1'b0;
   logic        mem_req_ready, mem_resp_valid;
   logic [31:0] mem_resp_data;

   icache_nway #(.NUM_WAYS(NUM_WAYS), .NUM_SETS(NUM_SETS), .LINE_WORDS(LINE_WORDS)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_data(resp_data), .hit(hit), .flush(flush), .flush_busy(flush_busy),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
      end
   endtask

   // Backing memory: a fixed function of the word address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] w;
      w = a & 32'hFFFF_FFFC;
      if (w == 32'h0000_1048) return 32'hDEAD_BEEF;
      return (w * 32'h9E37_79B9) ^ 32'h5A5A_1234 ^ {w[15:0], w[31:16]};
   endfunction

   // ---------------- reference model ----------------
   bit          mvalid [NUM_SETS][NUM_WAYS];
   logic [31:0] mtag   [NUM_SETS][NUM_WAYS];
   bit          mnode  [NUM_SETS][NUM_WAYS-1];   // a 1 means the victim lies in the upper half of the range

   function automatic int plru_victim(input int s);
      int lo, hi, n, mid;
      lo = 0; hi = NUM_WAYS; n = 0;
      while (hi - lo > 1) begin
         mid = (lo + hi) / 2;
         if (mnode[s][n]) begin lo = mid; n = 2 * n + 2; end
         else begin hi = mid; n = 2 * n + 1; end
      end
      return lo;
   endfunction

   function automatic void plru_touch(input int s, input int way);
      int lo, hi, n, mid;
      lo = 0; hi = NUM_WAYS; n = 0;
      while (hi - lo > 1) begin
         mid = (lo + hi) / 2;
         if (way < mid) begin mnode[s][n] = 1'b1; hi = mid; n = 2 * n + 1; end
         else begin mnode[s][n] = 1'b0; lo = mid; n = 2 * n + 2; end
      end
   endfunction

   function automatic bit model_access(input logic [31:0] a);
      int s, way;
      logic [31:0] t;
      s = int'((a >> OFF_W) % NUM_SETS);
      t = a >> (OFF_W + IDX_W);
      way = -1;
      for (int w = 0; w < NUM_WAYS; w++)
         if (mvalid[s][w] && mtag[s][w] == t) way = w;
      if (way >= 0) begin
         plru_touch(s, way);
         return 1'b1;
      end
      for (int w = NUM_WAYS - 1; w >= 0; w--)
         if (!mvalid[s][w]) way = w;
      if (way < 0) way = plru_victim(s);
      mvalid[s][way] = 1'b1;
      mtag[s][way]   = t;
      plru_touch(s, way);
      return 1'b0;
   endfunction

   function automatic void model_clear();
      for (int s = 0; s < NUM_SETS; s++) begin
         for (int w = 0; w < NUM_WAYS; w++) mvalid[s][w] = 1'b0;
         for (int n = 0; n < NUM_WAYS - 1; n++) mnode[s][n] = 1'b0;
      end
   endfunction

   // ---------------- scoreboard ----------------
   typedef struct { logic [31:0] data; logic hit; int cyc; } exp_t;
   exp_t        exp_q[$];
   logic [31:0] mreq_q[$];

   // Monitor: every response is popped and compared in order.
   always @(negedge clk) begin
      exp_t e;
      if (resp_valid) begin
         if (exp_q.size() == 0) begin
            chk("resp_unexpected", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("resp_data", resp_data, e.data);
            chk("resp_hit", {31'b0, hit}, {31'b0, e.hit});
            if (e.cyc >= 0) chk("hit_latency", cyc, e.cyc);
         end
      end
   end

   // ---------------- memory responder ----------------
   int req_stall_min = 0;
   int req_stall_max = 2;
   int gap_max       = 1;
   int beat_idx      = -1;
   bit mem_busy      = 1'b0;

   initial begin
      logic [31:0] a, ba;
      int n;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
      forever begin
         @(posedge clk); #1;
         if (mem_req_valid) begin
            a = mem_req_addr;
            mem_busy = 1'b1;
            if (mreq_q.size() == 0) chk("mem_req_unexpected", 32'd1, 32'd0);
            else chk("mem_req_addr", a, mreq_q.pop_front());
            n = $urandom_range(req_stall_max, req_stall_min);
            repeat (n) begin
               @(posedge clk); #1;
               chk("mem_req_hold_vld", {31'b0, mem_req_valid}, 32'd1);
               chk("mem_req_hold_addr", mem_req_addr, a);
            end
            mem_req_ready = 1'b1;
            @(posedge clk); #1;
            mem_req_ready = 1'b0;
            for (int k = 0; k < LINE_WORDS; k++) begin
               n = $urandom_range(gap_max, 0);
               repeat (n) begin @(posedge clk); #1; end
               ba = (a & ~(32'(LINE_WORDS * 4) - 32'd1)) | ((((a >> 2) + 32'(k)) % LINE_WORDS) << 2);
               mem_resp_valid = 1'b1;
               mem_resp_data  = mem_word(ba);
               beat_idx       = k;
               @(posedge clk); #1;
               mem_resp_valid = 1'b0;
               beat_idx       = -1;
            end
            mem_busy = 1'b0;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_idle(input string name);
      int w;
      w = 0;
      @(posedge clk); #1;
      while (!req_ready && w < 2000) begin @(posedge clk); #1; w++; end
      if (!req_ready) chk(name, 32'd0, 32'd1);
   endtask

   task automatic fetch(input logic [31:0] a);
      exp_t e;
      bit h;
      wait_idle("fetch_ready_timeout");
      if (!req_ready) return;
      h = model_access(a);
      e.data = mem_word(a);
      e.hit  = h;
      e.cyc  = h ? cyc + 1 : -1;
      exp_q.push_back(e);
      if (!h) mreq_q.push_back(a & 32'hFFFF_FFFC);
      req_valid = 1'b1;
      req_addr  = a;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_addr  = $urandom;
   endtask

   task automatic wait_beat(input int k, input string name);
      int w;
      w = 0;
      @(negedge clk);
      while (!(mem_resp_valid && beat_idx == k) && w < 500) begin @(negedge clk); w++; end
      if (!(mem_resp_valid && beat_idx == k)) chk(name, 32'd0, 32'd1);
   endtask

   // Flush issued while idle: busy for exactly NUM_SETS cycles, no requests accepted meanwhile.
   task automatic flush_from_idle();
      int n;
      bit rdy_seen;
      wait_idle("flush_idle_timeout");
      @(negedge clk);
      chk("flush_busy_before", {31'b0, flush_busy}, 32'd0);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      n = 0; rdy_seen = 1'b0;
      @(negedge clk);
      while (flush_busy && n < 300) begin
         n++;
         if (req_ready) rdy_seen = 1'b1;
         @(negedge clk);
      end
      chk("flush_idle_len", n, NUM_SETS);
      chk("flush_blocks_req", {31'b0, rdy_seen}, 32'd0);
      model_clear();
   endtask

   initial begin
      int n, w;
      bit rdy_seen;
      int sets_pool [3] = '{0, 1, 63};
      logic [31:0] a;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("rst_hit", {31'b0, hit}, 32'd0);
      chk("rst_resp_data", resp_data, 32'd0);
      chk("rst_mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
      chk("rst_mem_req_addr", mem_req_addr, 32'd0);
      chk("rst_flush_busy", {31'b0, flush_busy}, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      #1 chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
      model_clear();

      // Cold miss, then hit on beat 13 of the same line.
      fetch(32'h0000_1048);
      fetch(32'h0000_107C);

      // Five tags into one set: the fifth fill evicts the PLRU way, first tag then misses.
      for (int k = 0; k < 5; k++) fetch(32'h0010_0100 + 32'(k) * 32'h1000);
      fetch(32'h0010_0100);
      fetch(32'h0010_4104);

      // Held request and gappy fill, then read back every word of the wrapped line.
      req_stall_min = 5; req_stall_max = 5; gap_max = 3;
      fetch(32'h0000_3A74);
      req_stall_min = 0; req_stall_max = 2; gap_max = 1;
      for (int k = 0; k < LINE_WORDS; k++) fetch(32'h0000_3A40 + 32'(k) * 4);

      // Flush mid-fill: fill completes, a return to IDLE, then the full sweep.
      fetch(32'h0000_5008);
      wait_beat(3, "flush_beat_timeout");
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_busy_after_pulse", {31'b0, flush_busy}, 32'd1);
      w = 0;
      @(negedge clk);
      while (mem_busy && w < 500) begin @(negedge clk); w++; end
      n = 0; rdy_seen = 1'b0;
      while (flush_busy && n < 300) begin
         n++;
         if (req_ready) rdy_seen = 1'b1;
         @(negedge clk);
      end
      // One IDLE cycle may precede the NUM_SETS sweep cycles.
      chk("flush_fill_len", {31'b0, (n == NUM_SETS) || (n == NUM_SETS + 1)}, 32'd1);
      chk("flush_fill_blocks_req", {31'b0, rdy_seen}, 32'd0);
      model_clear();
      fetch(32'h0000_5008);
      fetch(32'h0000_107C);

      flush_from_idle();
      fetch(32'h0000_3A40);

      // Random traffic over a small conflict-heavy address pool.
      for (int i = 0; i < 250; i++) begin
         if ($urandom_range(24, 0) == 0) begin
            flush_from_idle();
         end else begin
            a = (32'($urandom_range(5, 0)) << (OFF_W + IDX_W)) |
                (32'(sets_pool[$urandom_range(2, 0)]) << OFF_W) |
                (32'($urandom_range(LINE_WORDS - 1, 0)) << 2) | 32'($urandom_range(3, 0));
            fetch(a);
         end
      end

      // Reset during beat 7: fill abandoned, remaining beats ignored, line misses again.
      fetch(32'h0000_7720);
      wait_beat(7, "reset_beat_timeout");
      rst_n = 1'b0;
      #1;
      chk("midfill_rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("midfill_rst_hit", {31'b0, hit}, 32'd0);
      chk("midfill_rst_resp_data", resp_data, 32'd0);
      chk("midfill_rst_mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
      chk("midfill_rst_flush_busy", {31'b0, flush_busy}, 32'd0);
      @(negedge clk);
      @(negedge clk) rst_n = 1'b1;
      #1 chk("midfill_rst_req_ready", {31'b0, req_ready}, 32'd1);
      model_clear();
      w = 0;
      while (mem_busy && w < 500) begin @(negedge clk); w++; end
      chk("midfill_beats_drained", {31'b0, mem_busy}, 32'd0);
      fetch(32'h0000_7720);
      fetch(32'h0000_7724);

      wait_idle("final_idle_timeout");
      repeat (3) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      chk("mem_req_drained", mreq_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/icache_nway.md
ICACHE_NWAY -- requirements
Module: icache_nway

Interface
REQ-001 SHALL have parameter NUM_WAYS, default 4, associativity; power of 2, range 2..8.
REQ-002 SHALL have parameter NUM_SETS, default 64, set count; power of 2.
REQ-003 SHALL have parameter LINE_WORDS, default 16, 32-bit words per line; power of 2, range 4..32.
REQ-004 SHALL use one clock and an asynchronous active-low reset, as listed first below.
REQ-005 SHALL provide ports: clk  in  1  clock, rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 req_valid  in  1  CPU fetch request.
REQ-008 req_addr  in  32  fetch byte address; bits [1:0] ignored.
REQ-009 req_ready  out  1  cache accepts a request this cycle.
REQ-010 resp_valid  out  1  resp_data valid, one-cycle pulse.
REQ-011 resp_data  out  32  fetched instruction word.
REQ-012 hit  out  1  lookup hit, qualified by resp_valid in LOOKUP.
REQ-013 flush  in  1  invalidate-all request (fence.i), one-cycle pulse.
REQ-014 flush_busy  out  1  flush pending or in progress.
REQ-015 mem_req_valid  out  1  line-fill request.
REQ-016 mem_req_ready  in  1  memory accepts line-fill request.
REQ-017 mem_req_addr  out  32  critical-word address of the fill.
REQ-018 mem_resp_valid  in  1  one fill beat valid.
REQ-019 mem_resp_data  in  32  fill beat data.

Function
REQ-020 Address split SHALL be offset = log2(LINE_WORDS)+2 bits, index = log2(NUM_SETS) bits, tag = remaining upper bits.
REQ-021 States SHALL be IDLE, LOOKUP, MISS_REQ, FILL, FLUSH.
REQ-022 req_ready SHALL be 1 only in IDLE with no flush pending; req_valid&req_ready latches the address and moves to LOOKUP.
REQ-023 LOOKUP on hit SHALL assert resp_valid=1, hit=1, resp_data=selected word, update the set PLRU, return to IDLE; hit latency 1 cycle after acceptance.
REQ-024 LOOKUP on miss SHALL select the victim (lowest-index invalid way, else PLRU victim), invalidate it immediately, and go to MISS_REQ; resp_valid=0.
REQ-025 MISS_REQ SHALL hold mem_req_valid=1 and mem_req_addr=critical-word address stable until mem_req_ready, then go to FILL.
REQ-026 Memory returns exactly LINE_WORDS beats in wrap order from the critical word; the cache SHALL write beat k to word (crit+k) mod LINE_WORDS.
REQ-027 The first beat SHALL drive resp_valid=1, hit=0, resp_data=mem_resp_data in the same cycle.
REQ-028 On the last beat the cache SHALL write tag, set valid, mark the victim MRU in PLRU, return to IDLE.
REQ-029 Beats with mem_resp_valid=0 SHALL stall the fill with no state change.
REQ-030 PLRU SHALL be a NUM_WAYS-1 bit tree per set; on access every node on the path points away from the accessed way.
REQ-031 flush in IDLE SHALL go to FLUSH; in any other state it SHALL be latched and serviced on the next return to IDLE, before any new request.
REQ-032 FLUSH SHALL clear valid and PLRU of one set per cycle, sets 0..NUM_SETS-1, then return to IDLE; duration NUM_SETS cycles.
REQ-033 flush_busy SHALL be 1 from the cycle after flush is sampled until FLUSH completes.
REQ-034 Data and tag arrays SHALL not be cleared by flush.

Reset
REQ-035 Reset SHALL force IDLE, all valid bits and PLRU to 0, pending flush to 0, all outputs to 0 except req_ready, which SHALL be 1 after reset release.
REQ-036 Reset mid-fill SHALL abandon the fill; the victim way stays invalid; subsequent beats are ignored.

Structure
REQ-037 State encoding and address-field width functions SHALL reside in shared package icache_pkg.
REQ-038 Victim selection and PLRU update SHALL be one sub-module plru_tree, parametrised by NUM_WAYS.

Verification
REQ-039 Cold miss 0x0000_1048 (defaults) -> mem_req_addr=0x0000_1048; beat 0 returns 0xDEAD_BEEF with resp_valid=1, hit=0; 16 beats; FILL->IDLE.
REQ-040 Re-fetch 0x0000_107C -> resp_valid=1, hit=1 one cycle after acceptance, data = beat 13 of that fill.
REQ-041 Five tags to one set with NUM_WAYS=4 -> fifth fill evicts the PLRU way; re-fetching the first tag misses.
REQ-042 flush asserted mid-FILL -> fill completes, then flush_busy=1 for 64 FLUSH cycles; every later fetch misses.
REQ-043 mem_req_ready held 0 for 5 cycles, mem_resp_valid gaps -> request stable, beats written to correct wrapped words.
REQ-044 rst_n low during beat 7 -> all outputs 0, req_ready=1 after release, same address misses.
